// File: rtl/shift_unit_arbiter.sv
// ---------------------------------------------------------------------------
// shift_unit_arbiter
//   Shares one 16-bit barrel shifter/rotator between two execute-stage
//   requesters:
//   - Port 0 is the ALU shift/rotate path.
//   - Port 1 is the address/immediate formatting path.
//   The winner's operands drive the shifter. The result is registered into a
//   single output stage with valid/ready backpressure. This gives one
//   operation per cycle with one cycle of latency.
//
// Parameters
//   PRIO_FIXED : 0 = round-robin between ports, 1 = port 0 always wins.
//
// Ports
//   clk, rst                : clock, asynchronous active-high reset
//   reqX_valid / reqX_ready : request handshake for port X (X = 0, 1)
//   reqX_a                  : 16-bit operand
//   reqX_amt                : shift amount 0..15
//   reqX_rotate             : 1 = rotate, 0 = logical shift (zero fill)
//   reqX_right              : 1 = right, 0 = left
//   reqX_tag                : opaque ID returned with the result
//   rsp_valid / rsp_ready   : result handshake
//   rsp_data                : shift/rotate result
//   rsp_src                 : port that issued the result
//   rsp_tag                 : tag of that request
// ---------------------------------------------------------------------------

module barrel_shift_rotate #(
    parameter int DATA_W = 16,
    parameter int AMT_W  = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [AMT_W-1:0]  amt,
    input  logic              rotate,
    input  logic              right,
    output logic [DATA_W-1:0] y
);
    logic [2*DATA_W-1:0] dbl;
    logic [2*DATA_W-1:0] rot_l;
    logic [2*DATA_W-1:0] rot_r;

    // Rotation is a shift of the operand concatenated with itself. The bits
    // pushed out of one copy reappear from the other copy, which gives
    // modulo-DATA_W rotation without a wrap-around mux.
    always_comb begin
        dbl   = {a, a};
        rot_l = dbl << amt;
        rot_r = dbl >> amt;
        if (rotate) begin
            y = right ? rot_r[DATA_W-1:0] : rot_l[2*DATA_W-1:DATA_W];
        end else begin
            y = right ? (a >> amt) : (a << amt);
        end
    end
endmodule

module shift_unit_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [3:0]  req0_amt,
    input  logic        req0_rotate,
    input  logic        req0_right,
    input  logic [2:0]  req0_tag,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [3:0]  req1_amt,
    input  logic        req1_rotate,
    input  logic        req1_right,
    input  logic [2:0]  req1_tag,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_src,
    output logic [2:0]  rsp_tag
);
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q,  rsp_data_d;
    logic        rsp_src_q,   rsp_src_d;
    logic [2:0]  rsp_tag_q,   rsp_tag_d;
    logic        last_grant_q, last_grant_d;

    logic        can_accept;
    logic        winner;
    logic        accept;
    logic [15:0] sh_a;
    logic [3:0]  sh_amt;
    logic        sh_rotate;
    logic        sh_right;
    logic [15:0] sh_y;
    logic [2:0]  win_tag;

    // Arbitration. With a single valid port that port wins. When neither port
    // is valid, the winner defaults to port 0 and its output is unused.
    always_comb begin
        can_accept = ~rsp_valid_q | rsp_ready;
        if (req0_valid && req1_valid) begin
            winner = PRIO_FIXED ? 1'b0 : ~last_grant_q;
        end else begin
            winner = req1_valid & ~req0_valid;
        end
        // The ready gating on rst keeps requesters from seeing an accept
        // that the asynchronously cleared state would then discard.
        req0_ready = ~rst & can_accept & req0_valid & ~winner;
        req1_ready = ~rst & can_accept & req1_valid &  winner;
        accept     = req0_ready | req1_ready;
    end

    // Operand mux into the shared shifter.
    always_comb begin
        sh_a      = winner ? req1_a      : req0_a;
        sh_amt    = winner ? req1_amt    : req0_amt;
        sh_rotate = winner ? req1_rotate : req0_rotate;
        sh_right  = winner ? req1_right  : req0_right;
        win_tag   = winner ? req1_tag    : req0_tag;
    end

    barrel_shift_rotate #(
        .DATA_W (16),
        .AMT_W  (4)
    ) u_shifter (
        .a      (sh_a),
        .amt    (sh_amt),
        .rotate (sh_rotate),
        .right  (sh_right),
        .y      (sh_y)
    );

    // Result stage: next-state.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_src_d    = rsp_src_q;
        rsp_tag_d    = rsp_tag_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            // Accepting also covers the case where a result drains on the
            // same edge, so rsp_valid stays high with no bubble.
            rsp_valid_d  = 1'b1;
            rsp_data_d   = sh_y;
            rsp_src_d    = winner;
            rsp_tag_d    = win_tag;
            last_grant_d = winner;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Result stage: registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 16'h0000;
            rsp_src_q    <= 1'b0;
            rsp_tag_q    <= 3'd0;
            // Reset to 1 so that port 0 wins the first contention.
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_src_q    <= rsp_src_d;
            rsp_tag_q    <= rsp_tag_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_src   = rsp_src_q;
    assign rsp_tag   = rsp_tag_q;
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_unit_arbiter
//   Directed bench for shift_unit_arbiter. Two instances share the same
//   stimulus:
//   - u_rr is the round-robin configuration.
//   - u_fx is the fixed-priority configuration.
//   Inputs are driven just after the falling edge. Ready outputs are checked
//   1 time unit later. Registered outputs are sampled 1 time unit after the
//   rising edge.
// ---------------------------------------------------------------------------

module tb_shift_unit_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req0_valid = 1'b0, req0_rotate = 1'b0, req0_right = 1'b0;
    logic [15:0] req0_a = '0;
    logic [3:0]  req0_amt = '0;
    logic [2:0]  req0_tag = '0;
    logic        req1_valid = 1'b0, req1_rotate = 1'b0, req1_right = 1'b0;
    logic [15:0] req1_a = '0;
    logic [3:0]  req1_amt = '0;
    logic [2:0]  req1_tag = '0;
    logic        rsp_ready = 1'b1;

    logic        rr_req0_ready, rr_req1_ready, rr_rsp_valid, rr_rsp_src;
    logic [15:0] rr_rsp_data;
    logic [2:0]  rr_rsp_tag;
    logic        fx_req0_ready, fx_req1_ready, fx_rsp_valid, fx_rsp_src;
    logic [15:0] fx_rsp_data;
    logic [2:0]  fx_rsp_tag;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    shift_unit_arbiter #(.PRIO_FIXED(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_a(req0_a),
        .req0_amt(req0_amt), .req0_rotate(req0_rotate), .req0_right(req0_right),
        .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_a(req1_a),
        .req1_amt(req1_amt), .req1_rotate(req1_rotate), .req1_right(req1_right),
        .req1_tag(req1_tag),
        .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rr_rsp_data),
        .rsp_src(rr_rsp_src), .rsp_tag(rr_rsp_tag)
    );

    shift_unit_arbiter #(.PRIO_FIXED(1'b1)) u_fx (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fx_req0_ready), .req0_a(req0_a),
        .req0_amt(req0_amt), .req0_rotate(req0_rotate), .req0_right(req0_right),
        .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(fx_req1_ready), .req1_a(req1_a),
        .req1_amt(req1_amt), .req1_rotate(req1_rotate), .req1_right(req1_right),
        .req1_tag(req1_tag),
        .rsp_valid(fx_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(fx_rsp_data),
        .rsp_src(fx_rsp_src), .rsp_tag(fx_rsp_tag)
    );

    task automatic drop_reqs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic set_req0(input logic [15:0] a, input logic [3:0] amt,
                            input logic rot, input logic rgt, input logic [2:0] tag);
        req0_valid = 1'b1; req0_a = a; req0_amt = amt;
        req0_rotate = rot; req0_right = rgt; req0_tag = tag;
    endtask

    task automatic set_req1(input logic [15:0] a, input logic [3:0] amt,
                            input logic rot, input logic rgt, input logic [2:0] tag);
        req1_valid = 1'b1; req1_a = a; req1_amt = amt;
        req1_rotate = rot; req1_right = rgt; req1_tag = tag;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drop_reqs();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        set_req0(16'h1111, 4'd1, 1'b0, 1'b0, 3'd1);
        set_req1(16'h2222, 4'd1, 1'b0, 1'b0, 3'd2);
        #1;
        total_cnt++;
        if (rr_rsp_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", rr_rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (rr_rsp_data !== 16'h0000 || rr_rsp_src !== 1'b0 || rr_rsp_tag !== 3'd0)
            $display("FAIL reset_fields got data=%h src=%b tag=%0d want 0000/0/0",
                     rr_rsp_data, rr_rsp_src, rr_rsp_tag);
        else pass_cnt++;
        total_cnt++;
        if ({rr_req0_ready, rr_req1_ready, fx_req0_ready, fx_req1_ready} !== 4'b0000)
            $display("FAIL reset_ready got %b want 0000",
                     {rr_req0_ready, rr_req1_ready, fx_req0_ready, fx_req1_ready});
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rr_rsp_valid !== 1'b0 || rr_req0_ready !== 1'b0)
            $display("FAIL reset_hold got valid=%b ready0=%b want 0/0", rr_rsp_valid, rr_req0_ready);
        else pass_cnt++;
        @(negedge clk);
        drop_reqs();
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        set_req0(16'h8001, 4'd1, 1'b1, 1'b0, 3'd5);
        rsp_ready = 1'b1;
        #1;
        total_cnt++;
        if (rr_req0_ready !== 1'b1) $display("FAIL single_ready got %b want 1", rr_req0_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rr_rsp_valid !== 1'b1 || rr_rsp_data !== 16'h0003 || rr_rsp_src !== 1'b0 || rr_rsp_tag !== 3'd5)
            $display("FAIL single_rsp got v=%b d=%h s=%b t=%0d want 1/0003/0/5",
                     rr_rsp_valid, rr_rsp_data, rr_rsp_src, rr_rsp_tag);
        else pass_cnt++;
        @(negedge clk);
        drop_reqs();
        @(posedge clk);
        #1;
        total_cnt++;
        if (rr_rsp_valid !== 1'b0 || rr_rsp_data !== 16'h0003)
            $display("FAIL single_drain got v=%b d=%h want 0/0003", rr_rsp_valid, rr_rsp_data);
        else pass_cnt++;
    endtask

    task automatic test_corners();
        logic [15:0] a_t   [4] = '{16'h8000, 16'h1234, 16'hFFFF, 16'hA5A5};
        logic [3:0]  amt_t [4] = '{4'd15, 4'd8, 4'd4, 4'd0};
        logic        rot_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        rgt_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] exp_t [4] = '{16'h0001, 16'h3412, 16'hFFF0, 16'hA5A5};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req0_valid = 1'b0;
            set_req1(a_t[i], amt_t[i], rot_t[i], rgt_t[i], 3'(i + 1));
            #1;
            total_cnt++;
            if (rr_req1_ready !== 1'b1) $display("FAIL corner%0d_ready got %b want 1", i, rr_req1_ready);
            else pass_cnt++;
            @(posedge clk);
            #1;
            total_cnt++;
            if (rr_rsp_valid !== 1'b1 || rr_rsp_data !== exp_t[i] || rr_rsp_src !== 1'b1 ||
                rr_rsp_tag !== 3'(i + 1))
                $display("FAIL corner%0d got v=%b d=%h s=%b t=%0d want 1/%h/1/%0d",
                         i, rr_rsp_valid, rr_rsp_data, rr_rsp_src, rr_rsp_tag, exp_t[i], i + 1);
            else pass_cnt++;
        end
        @(negedge clk);
        drop_reqs();
    endtask

    // Round-robin contention followed directly by a stall of the last result.
    task automatic test_round_robin_backpressure();
        logic [15:0] sd;
        logic        ss;
        logic [2:0]  st;
        do_reset();
        set_req0(16'h0001, 4'd1, 1'b0, 1'b0, 3'd1);
        set_req1(16'h8000, 4'd1, 1'b0, 1'b1, 3'd2);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (rr_rsp_valid !== 1'b1 || rr_rsp_src !== 1'(k % 2) ||
                rr_rsp_data !== ((k % 2) ? 16'h4000 : 16'h0002) ||
                rr_rsp_tag !== ((k % 2) ? 3'd2 : 3'd1))
                $display("FAIL rr%0d got v=%b s=%b d=%h t=%0d want src %0d", k,
                         rr_rsp_valid, rr_rsp_src, rr_rsp_data, rr_rsp_tag, k % 2);
            else pass_cnt++;
        end
        sd = rr_rsp_data; ss = rr_rsp_src; st = rr_rsp_tag;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
            total_cnt++;
            if (rr_req0_ready !== 1'b0 || rr_req1_ready !== 1'b0)
                $display("FAIL stall%0d_ready got %b%b want 00", k, rr_req0_ready, rr_req1_ready);
            else pass_cnt++;
            @(posedge clk);
            #1;
            total_cnt++;
            if (rr_rsp_valid !== 1'b1 || rr_rsp_data !== sd || rr_rsp_src !== ss || rr_rsp_tag !== st)
                $display("FAIL stall%0d_hold got v=%b d=%h s=%b t=%0d want 1/%h/%b/%0d",
                         k, rr_rsp_valid, rr_rsp_data, rr_rsp_src, rr_rsp_tag, sd, ss, st);
            else pass_cnt++;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        total_cnt++;
        if (rr_req0_ready !== 1'b1 || rr_req1_ready !== 1'b0)
            $display("FAIL release_ready got %b%b want 10", rr_req0_ready, rr_req1_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rr_rsp_valid !== 1'b1 || rr_rsp_src !== 1'b0 || rr_rsp_data !== 16'h0002 || rr_rsp_tag !== 3'd1)
            $display("FAIL release_rsp got v=%b s=%b d=%h t=%0d want 1/0/0002/1",
                     rr_rsp_valid, rr_rsp_src, rr_rsp_data, rr_rsp_tag);
        else pass_cnt++;
    endtask

    // Entered with rr holding a valid port-0 result (last_grant = 0).
    task automatic test_reset_midflight();
        @(negedge clk);
        rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (rr_rsp_valid !== 1'b0 || rr_rsp_data !== 16'h0000)
            $display("FAIL midrst_async got v=%b d=%h want 0/0000", rr_rsp_valid, rr_rsp_data);
        else pass_cnt++;
        total_cnt++;
        if (rr_req0_ready !== 1'b0 || rr_req1_ready !== 1'b0)
            $display("FAIL midrst_ready got %b%b want 00", rr_req0_ready, rr_req1_ready);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        total_cnt++;
        if (rr_req0_ready !== 1'b1 || rr_req1_ready !== 1'b0)
            $display("FAIL midrst_first got %b%b want 10", rr_req0_ready, rr_req1_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rr_rsp_valid !== 1'b1 || rr_rsp_src !== 1'b0)
            $display("FAIL midrst_rsp got v=%b s=%b want 1/0", rr_rsp_valid, rr_rsp_src);
        else pass_cnt++;
    endtask

    task automatic test_fixed();
        do_reset();
        set_req0(16'h00F0, 4'd4, 1'b0, 1'b1, 3'd3);
        set_req1(16'h000F, 4'd4, 1'b0, 1'b0, 3'd4);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            total_cnt++;
            if (fx_req0_ready !== 1'b1 || fx_req1_ready !== 1'b0)
                $display("FAIL fixed%0d_ready got %b%b want 10", k, fx_req0_ready, fx_req1_ready);
            else pass_cnt++;
            @(posedge clk);
            #1;
            total_cnt++;
            if (fx_rsp_valid !== 1'b1 || fx_rsp_src !== 1'b0 || fx_rsp_data !== 16'h000F || fx_rsp_tag !== 3'd3)
                $display("FAIL fixed%0d_rsp got v=%b s=%b d=%h t=%0d want 1/0/000F/3",
                         k, fx_rsp_valid, fx_rsp_src, fx_rsp_data, fx_rsp_tag);
            else pass_cnt++;
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        total_cnt++;
        if (fx_req1_ready !== 1'b1) $display("FAIL fixed_p1_ready got %b want 1", fx_req1_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (fx_rsp_src !== 1'b1 || fx_rsp_data !== 16'h00F0 || fx_rsp_tag !== 3'd4)
            $display("FAIL fixed_p1_rsp got s=%b d=%h t=%0d want 1/00F0/4", fx_rsp_src, fx_rsp_data, fx_rsp_tag);
        else pass_cnt++;
        @(negedge clk);
        drop_reqs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_corners();
        test_round_robin_backpressure();
        test_reset_midflight();
        test_fixed();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/shift_unit_arbiter.md
# shift_unit_arbiter

Shares one 16-bit barrel shifter/rotator (`barrel_shift_rotate`, instantiated internally) between two execute-stage requesters: port 0 is the ALU shift/rotate path and port 1 is the address/immediate formatting path. Each cycle the block arbitrates between the two valid/ready request ports and applies the winner's operands to the shifter. It registers the result into a single output stage with valid/ready backpressure. Sustained throughput is one operation per cycle, with one cycle of latency.

## Interface
- PRIO_FIXED, default 0: 0 = round-robin between ports; 1 = port 0 always wins when valid.
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- reqX_valid  input  1  port X (X = 0, 1) has a request; must be held with stable payload until reqX_ready.
- reqX_ready  output  1  port X request is accepted this cycle.
- reqX_a  input  16  operand to shift or rotate.
- reqX_amt  input  4  shift amount, 0–15.
- reqX_rotate  input  1  1 = rotate, 0 = logical shift (zero fill).
- reqX_right  input  1  1 = right, 0 = left.
- reqX_tag  input  3  opaque ID, returned unchanged with the result.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_data  output  16  shift/rotate result.
- rsp_src  output  1  port that issued the result.
- rsp_tag  output  3  tag of that request.

## Operation
- can_accept = ~rsp_valid | rsp_ready. The output register is free, or is being drained this cycle.
- Winner selection (combinational):
  - Only one port valid: that port wins.
  - Both valid, PRIO_FIXED = 0: the port not equal to last_grant wins.
  - Both valid, PRIO_FIXED = 1: port 0 wins.
- reqX_ready = can_accept & reqX_valid & (winner == X). At most one ready is asserted per cycle.
- reqX_ready depends combinationally on the reqX_valid inputs and rsp_ready. Requesters must not derive valid from ready.
- Shifter inputs are muxed from the winner's a/amt/rotate/right fields. When neither port is valid, the mux selects port 0; its output is unused.
- Shifter semantics:
  - Logical shift fills vacated bits with 0.
  - Rotate is modulo 16.
  - amt = 0 passes a through unchanged.
- Accept (some reqX_valid & reqX_ready):
  - The next edge loads rsp_data = shifter output, rsp_src = X, rsp_tag = reqX_tag, rsp_valid = 1.
  - last_grant <= X.
- Drain without accept (rsp_valid & rsp_ready, no request accepted): rsp_valid <= 0. rsp_data, rsp_src and rsp_tag hold their values.
- Stall (rsp_valid & ~rsp_ready): all output fields and last_grant hold; both reqX_ready = 0.
- last_grant changes only on an accepted transfer. Idle cycles and stalls do not move it.
- Starvation bound (PRIO_FIXED = 0): a continuously valid port is granted within 2 accepted transfers.

## Timing
- Reset values (applied asynchronously while rst is high):
  - rsp_valid = 0, rsp_data = 0x0000, rsp_src = 0, rsp_tag = 0.
  - last_grant = 1, so port 0 wins the first contention.
- Latency: a request accepted in cycle N presents rsp_valid = 1 with its data in cycle N+1.
- Throughput: with rsp_ready held at 1, one request is accepted every cycle (back-to-back).
- Simultaneous drain and accept in one cycle: the old result is consumed and the new result loads on the same edge. rsp_valid stays 1 with no bubble.
- Reset mid-operation: any pending result is discarded and the arbitration pointer returns to its reset value. Requesters must re-present their requests after rst deasserts.
- reqX_ready is held at 0 throughout reset.
- First accept is possible in the first cycle after rst deasserts.

## Test plan
- Single request: req0 with a = 0x8001, amt = 1, rotate = 1, right = 0, tag = 5; rsp_ready = 1. Required: req0_ready = 1 in the same cycle; next cycle rsp_valid = 1, rsp_data = 0x0003, rsp_src = 0, rsp_tag = 5.
- Arithmetic corners, each issued on port 1:
  - Logical right shift of 0x8000, amt = 15 → 0x0001.
  - Right rotate of 0x1234, amt = 8 → 0x3412.
  - Left shift of 0xFFFF, amt = 4 → 0xFFF0.
  - amt = 0 on 0xA5A5 → 0xA5A5.
- Contention, round-robin: both ports valid for 6 cycles, rsp_ready = 1 (first contention after reset). Required: rsp_src sequence 0,1,0,1,0,1, with rsp_valid high every cycle after the first.
- Backpressure: rsp_valid = 1 with rsp_ready = 0 for 3 cycles while both ports are valid. Required: both reqX_ready = 0, and rsp_data/rsp_src/rsp_tag stable. On release, the stalled result drains and the next winner loads on the same edge.
- Fixed priority: PRIO_FIXED = 1, both ports valid for 4 cycles. Required: port 0 is granted every cycle. When req0_valid drops, port 1 is granted the next cycle.
- Reset mid-flight: assert rst while rsp_valid = 1 and last_grant = 0. Required: rsp_valid = 0 immediately, without waiting for a clock edge. On the first contention after release, port 0 wins.
